coded_sym_serializer: RTL and testbench
=======================================

# coded_sym_serializer

Downstream stage of the LE Coded PHY FEC encoder/pattern mapper. Buffers the per-bit mapped codewords (2 bits for S=2, 8 bits for S=8) in a small FIFO. Shifts them out one symbol per symbol-rate tick as a serial stream to the modulator front end. Handles FEC/mapper bursts versus steady symbol pacing, and flags underruns.

## Interface
Parameters:
- FIFO_DEPTH, 4, codeword entries; power of two, ≥2
- PTR_W, $clog2(FIFO_DEPTH), FIFO pointer width

Ports:
- pka_1or2m_gclk  in  1  system clock
- r_tx_rst_n  in  1  asynchronous, active-low reset
- s  in  1  coding scheme of the incoming word: 1 = S=8, 0 = S=2
- code_data_2  in  2  S=2 mapped codeword {a0,a1}
- code_data_8  in  8  S=8 mapped codeword {a0 pattern, a1 pattern}
- code_wr  in  1  codeword write strobe, one cycle per encoded input bit
- code_rdy  out  1  FIFO not full; registered
- sym_ce  in  1  symbol-rate tick, one cycle wide
- ser_en  in  1  packet active; low = no further words will arrive
- tx_sym  out  1  serial coded symbol; registered
- tx_sym_vld  out  1  one-cycle pulse, tx_sym updated
- ser_busy  out  1  state != IDLE
- underrun  out  1  sticky; FIFO empty at a word boundary while ser_en high

## Operation
- Write: when code_wr && code_rdy, store {6'b0,code_data_2} if s=0, else code_data_8, into FIFO. A write while full is dropped.
- Scheme latch: s_lat <= s on the IDLE->RUN transition. s changes after that are ignored until IDLE.
- Word length L = 8 if s_lat else 2. Bits are emitted MSB first: S=8 bit7..bit0; S=2 bit1 (a0), then bit0 (a1).
- FSM:
  - IDLE -> RUN when FIFO non-empty. Pop the head into shift register sh; bit counter cnt=0.
  - RUN, on sym_ce: tx_sym <= current MSB; tx_sym_vld pulses; cnt++.
    - If cnt==L-1 and FIFO non-empty: pop the next word in the same cycle; cnt=0.
    - If cnt==L-1, FIFO empty, ser_en=1: go to STALL; set underrun.
    - If cnt==L-1, FIFO empty, ser_en=0: go to IDLE.
  - STALL: no tx_sym_vld.
    - On sym_ce with FIFO non-empty: pop, emit its first bit, go to RUN (cnt=1).
    - If ser_en falls while FIFO empty: go to IDLE.
- Simultaneous pop and write: both occur. code_rdy for the next cycle reflects the net count.
- ser_en low does not abort. All buffered words drain fully.
- underrun clears only on reset or on the IDLE->RUN transition.

## Timing
- Reset values: tx_sym=0, tx_sym_vld=0, code_rdy=1, ser_busy=0, underrun=0, state IDLE, FIFO empty, s_lat=0.
- Write at cycle t, FIFO empty, state IDLE: RUN at t+1. The first sym_ce at cycle ≥t+1 drives tx_sym/tx_sym_vld valid one cycle later.
- Pops occur only in the IDLE->RUN transition cycle or in a sym_ce cycle. Back-to-back words produce no symbol gap.
- sym_ce in IDLE is ignored.
- FIFO pointers wrap modulo FIFO_DEPTH. Count is PTR_W+1 bits.

## Configuration
- CODED_SER_STATUS_EN defined:
  - Adds output overflow (sticky; write attempted while full).
  - Adds output sym_cnt[15:0]: symbols emitted since the last IDLE->RUN, saturating at 16'hFFFF.
  - Both reset to 0.
- Undefined: neither port exists, and dropped writes are silent.

## Structure
- Package coded_ser_pkg holds:
  - state enum {IDLE, RUN, STALL}
  - S2_LEN=2, S8_LEN=8
  - SCHEME_S2=1'b0, SCHEME_S8=1'b1
- Sub-module coded_ser_fifo: synchronous FIFO, 8-bit wide, FIFO_DEPTH deep. Provides full/empty/count, push/pop, async active-low reset. Top level holds FSM, shift register and counters.

## Test plan
- S=8: write 8'hC3 in IDLE, ser_en=1, sym_ce every 4 cycles -> tx_sym 1,1,0,0,0,0,1,1. Then STALL, underrun=1.
- S=2: write 2'b10, 2'b01 back-to-back, ser_en=1, then drop ser_en -> tx_sym 1,0,0,1 with no gap. Then IDLE, ser_busy=0, underrun=0.
- Full: FIFO_DEPTH=4, no sym_ce, 5 writes -> code_rdy=0 after the 4th write, 5th dropped (overflow=1 with CODED_SER_STATUS_EN). Only 4 words emitted.
- Underrun/resume: single S=2 word, ser_en high. After 2 symbols, write 2'b11 three ticks later -> no tx_sym_vld in between, underrun=1, then 1,1.
- s toggled mid-packet after an S=8 start -> word lengths remain 8 until IDLE.
- r_tx_rst_n pulsed low mid-word -> outputs immediately at reset values, FIFO empty. Next packet starts cleanly from IDLE.

Source files
------------

// File: rtl/coded_ser_pkg.sv
// Purpose : shared types and constants for the coded symbol serializer.
// Latency : n/a (package only).
// Backpr. : n/a.
// Contents: state_e FSM encoding, word lengths, scheme codes, word alignment helpers.
package coded_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_e;

  localparam int unsigned S2_LEN = 2;
  localparam int unsigned S8_LEN = 8;

  localparam logic SCHEME_S2 = 1'b0;
  localparam logic SCHEME_S8 = 1'b1;

  // Left-justify a stored word so the next symbol to send is always bit 7.
  // S=2 words live in bits [1:0] of the FIFO entry.
  function automatic logic [7:0] align_word(input logic [7:0] w, input logic scheme);
    return (scheme == SCHEME_S8) ? w : {w[1:0], 6'b0};
  endfunction

  // Index of the last symbol of a word, as seen by the 3-bit bit counter.
  function automatic logic [2:0] last_idx(input logic scheme);
    return (scheme == SCHEME_S8) ? 3'(S8_LEN - 1) : 3'(S2_LEN - 1);
  endfunction

endpackage

// File: rtl/coded_ser_fifo.sv
// Purpose : 8-bit synchronous FIFO buffering mapped codewords.
// Latency : push visible as head one cycle after the write edge; pop takes effect on the edge.
// Backpr. : pushes while full and pops while empty are ignored.
// Ports   : clk/rst_n (async active-low), push/push_dat, pop, head_dat, full, empty, count.
module coded_ser_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [7:0]       push_dat,
  input  logic             pop,
  output logic [7:0]       head_dat,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = mem[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are PTR_W bits, so wrap modulo FIFO_DEPTH falls out naturally.
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/coded_sym_serializer.sv
// Purpose : buffers LE Coded PHY mapped codewords (S=2 / S=8) and shifts them out MSB first,
//           one symbol per sym_ce, flagging underruns. Optional status: CODED_SER_STATUS_EN.
// Latency : write to RUN one cycle; tx_sym/tx_sym_vld registered one cycle after sym_ce.
// Backpr. : code_rdy (registered, FIFO not full); writes while full are dropped.
// Ports   : s/code_data_2/code_data_8/code_wr/code_rdy in, sym_ce/ser_en control,
//           tx_sym/tx_sym_vld/ser_busy/underrun out (+overflow/sym_cnt with CODED_SER_STATUS_EN).
module coded_sym_serializer
  import coded_ser_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic        pka_1or2m_gclk,
  input  logic        r_tx_rst_n,
  input  logic        s,
  input  logic [1:0]  code_data_2,
  input  logic [7:0]  code_data_8,
  input  logic        code_wr,
  output logic        code_rdy,
  input  logic        sym_ce,
  input  logic        ser_en,
  output logic        tx_sym,
  output logic        tx_sym_vld,
  output logic        ser_busy,
  output logic        underrun
`ifdef CODED_SER_STATUS_EN
  ,
  output logic        overflow,
  output logic [15:0] sym_cnt
`endif
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  state_e      state_q, state_d;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        s_lat_q, s_lat_d;
  logic        tx_sym_q, tx_sym_d;
  logic        tx_sym_vld_q, tx_sym_vld_d;
  logic        underrun_q, underrun_d;
  logic        code_rdy_q, code_rdy_d;
  logic        run_start;

  logic [7:0]     wr_dat, fifo_head, head_al_s, head_al_lat;
  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PTR_W:0] fifo_count, count_nxt;
  logic           word_last;

  assign wr_dat    = (s == SCHEME_S8) ? code_data_8 : {6'b0, code_data_2};
  assign fifo_push = code_wr && !fifo_full;

  coded_ser_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .PTR_W      (PTR_W)
  ) u_fifo (
    .clk      (pka_1or2m_gclk),
    .rst_n    (r_tx_rst_n),
    .push     (fifo_push),
    .push_dat (wr_dat),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // The first word of a packet aligns with the live s, later words with the latched scheme.
  assign head_al_s   = align_word(fifo_head, s);
  assign head_al_lat = align_word(fifo_head, s_lat_q);
  assign word_last   = (cnt_q == last_idx(s_lat_q));

  // code_rdy is registered, so it is computed from the post-edge occupancy.
  assign count_nxt  = fifo_count + (PTR_W + 1)'(fifo_push) - (PTR_W + 1)'(fifo_pop);
  assign code_rdy_d = (count_nxt != FULL_CNT);

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    s_lat_d      = s_lat_q;
    tx_sym_d     = tx_sym_q;
    tx_sym_vld_d = 1'b0;
    underrun_d   = underrun_q;
    fifo_pop     = 1'b0;
    run_start    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          run_start  = 1'b1;
          s_lat_d    = s;
          sh_d       = head_al_s;
          cnt_d      = 3'd0;
          underrun_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (sym_ce) begin
          tx_sym_d     = sh_q[7];
          tx_sym_vld_d = 1'b1;
          sh_d         = {sh_q[6:0], 1'b0};
          cnt_d        = cnt_q + 3'd1;
          if (word_last) begin
            if (!fifo_empty) begin
              // Reload in the same tick so consecutive words have no symbol gap.
              fifo_pop = 1'b1;
              sh_d     = head_al_lat;
              cnt_d    = 3'd0;
            end else if (ser_en) begin
              state_d    = STALL;
              underrun_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      STALL: begin
        if (sym_ce && !fifo_empty) begin
          // Resume immediately: this tick already carries the new word's first bit.
          fifo_pop     = 1'b1;
          tx_sym_d     = head_al_lat[7];
          tx_sym_vld_d = 1'b1;
          sh_d         = {head_al_lat[6:0], 1'b0};
          cnt_d        = 3'd1;
          state_d      = RUN;
        end else if (!ser_en && fifo_empty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pka_1or2m_gclk or negedge r_tx_rst_n) begin
    if (!r_tx_rst_n) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      cnt_q        <= '0;
      s_lat_q      <= 1'b0;
      tx_sym_q     <= 1'b0;
      tx_sym_vld_q <= 1'b0;
      underrun_q   <= 1'b0;
      code_rdy_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      s_lat_q      <= s_lat_d;
      tx_sym_q     <= tx_sym_d;
      tx_sym_vld_q <= tx_sym_vld_d;
      underrun_q   <= underrun_d;
      code_rdy_q   <= code_rdy_d;
    end
  end

  assign tx_sym     = tx_sym_q;
  assign tx_sym_vld = tx_sym_vld_q;
  assign ser_busy   = (state_q != IDLE);
  assign underrun   = underrun_q;
  assign code_rdy   = code_rdy_q;

`ifdef CODED_SER_STATUS_EN
  logic        overflow_q, overflow_d;
  logic [15:0] sym_cnt_q, sym_cnt_d;

  always_comb begin
    overflow_d = overflow_q | (code_wr && fifo_full);
    sym_cnt_d  = sym_cnt_q;
    if (run_start)
      sym_cnt_d = 16'd0;
    else if (tx_sym_vld_d && (sym_cnt_q != 16'hFFFF))
      sym_cnt_d = sym_cnt_q + 16'd1;
  end

  always_ff @(posedge pka_1or2m_gclk or negedge r_tx_rst_n) begin
    if (!r_tx_rst_n) begin
      overflow_q <= 1'b0;
      sym_cnt_q  <= 16'd0;
    end else begin
      overflow_q <= overflow_d;
      sym_cnt_q  <= sym_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign sym_cnt  = sym_cnt_q;
`endif

endmodule

// File: tb/tb_coded_sym_serializer.sv
// Directed bench for coded_sym_serializer: S=8 and S=2 streaming, FIFO full,
// underrun and resume, scheme latch, and asynchronous reset mid-word.
module tb_coded_sym_serializer;

  logic        clk;
  logic        rst_n;
  logic        s;
  logic [1:0]  code_data_2;
  logic [7:0]  code_data_8;
  logic        code_wr;
  logic        code_rdy;
  logic        sym_ce;
  logic        ser_en;
  logic        tx_sym;
  logic        tx_sym_vld;
  logic        ser_busy;
  logic        underrun;
`ifdef CODED_SER_STATUS_EN
  logic        overflow;
  logic [15:0] sym_cnt;
`endif

  int tests = 0;
  int fails = 0;

  coded_sym_serializer #(.FIFO_DEPTH(4)) dut (
    .pka_1or2m_gclk (clk),
    .r_tx_rst_n     (rst_n),
    .s              (s),
    .code_data_2    (code_data_2),
    .code_data_8    (code_data_8),
    .code_wr        (code_wr),
    .code_rdy       (code_rdy),
    .sym_ce         (sym_ce),
    .ser_en         (ser_en),
    .tx_sym         (tx_sym),
    .tx_sym_vld     (tx_sym_vld),
    .ser_busy       (ser_busy),
    .underrun       (underrun)
`ifdef CODED_SER_STATUS_EN
    ,
    .overflow       (overflow),
    .sym_cnt        (sym_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One symbol tick; the registered symbol is checked one cycle later.
  task automatic sym(input string tag, input logic exp_bit);
    sym_ce = 1'b1;
    tick();
    sym_ce = 1'b0;
    chk1({tag, "_vld"}, tx_sym_vld, 1'b1);
    chk1({tag, "_bit"}, tx_sym, exp_bit);
  endtask

  task automatic wr2(input logic [1:0] d);
    code_wr = 1'b1; s = 1'b0; code_data_2 = d;
    tick();
    code_wr = 1'b0;
  endtask

  task automatic wr8(input logic [7:0] d);
    code_wr = 1'b1; s = 1'b1; code_data_8 = d;
    tick();
    code_wr = 1'b0;
  endtask

  initial begin
    logic [7:0]  v8;
    logic [15:0] v16;
    logic [4:0]  rdy_exp;
    logic [9:0]  full_bits;

    rst_n = 1'b0; s = 1'b0; code_data_2 = '0; code_data_8 = '0;
    code_wr = 1'b0; sym_ce = 1'b0; ser_en = 1'b0;
    tick(); tick();

    // ---- reset values
    chk1("rst_tx_sym", tx_sym, 1'b0);
    chk1("rst_vld", tx_sym_vld, 1'b0);
    chk1("rst_code_rdy", code_rdy, 1'b1);
    chk1("rst_busy", ser_busy, 1'b0);
    chk1("rst_underrun", underrun, 1'b0);
`ifdef CODED_SER_STATUS_EN
    chk1("rst_overflow", overflow, 1'b0);
    chk16("rst_sym_cnt", sym_cnt, 16'h0000);
`endif
    rst_n = 1'b1;
    tick();

    // ---- S=8 word C3, sym_ce every 4 cycles, ends in STALL with underrun
    ser_en = 1'b1;
    wr8(8'hC3);
    chk1("s8_busy_idle_still", ser_busy, 1'b0);
    tick();
    chk1("s8_busy_run", ser_busy, 1'b1);
    v8 = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      sym($sformatf("s8_b%0d", i), v8[i]);
      if (i == 7) chk1("s8_no_underrun_yet", underrun, 1'b0);
      tick();
      chk1($sformatf("s8_gap_b%0d", i), tx_sym_vld, 1'b0);
      tick(); tick();
    end
    chk1("s8_stall_underrun", underrun, 1'b1);
    chk1("s8_stall_busy", ser_busy, 1'b1);
    ser_en = 1'b0;
    tick();
    chk1("s8_idle_busy", ser_busy, 1'b0);
    chk1("s8_underrun_sticky", underrun, 1'b1);

    // ---- S=2 back-to-back words 10, 01 with no gap; drains to IDLE
    code_wr = 1'b1; s = 1'b0; code_data_2 = 2'b10;
    tick();
    code_data_2 = 2'b01;
    tick();
    code_wr = 1'b0;
    chk1("s2_underrun_cleared", underrun, 1'b0);
    sym("s2_0", 1'b1);
    sym("s2_1", 1'b0);
    sym("s2_2", 1'b0);
    sym("s2_3", 1'b1);
    tick();
    chk1("s2_idle_busy", ser_busy, 1'b0);
    chk1("s2_underrun", underrun, 1'b0);

    // ---- FIFO full: stall first, then 5 writes with no sym_ce
    ser_en = 1'b1;
    wr2(2'b11);
    tick();
    sym("full_pre0", 1'b1);
    sym("full_pre1", 1'b1);
    chk1("full_pre_underrun", underrun, 1'b1);
    rdy_exp   = 5'b00111;          // code_rdy after write k is rdy_exp[k]
    full_bits = 10'b10_01_11_00_10;
    code_wr = 1'b1; s = 1'b0;
    for (int k = 0; k < 5; k++) begin
      code_data_2 = full_bits[9 - 2*k -: 2];
      tick();
      chk1($sformatf("full_rdy_w%0d", k), code_rdy, rdy_exp[k]);
    end
    code_wr = 1'b0;
`ifdef CODED_SER_STATUS_EN
    chk1("full_overflow", overflow, 1'b1);
`endif
    ser_en = 1'b0;
    tick();
    chk1("full_hold_stall", ser_busy, 1'b1);
    v8 = 8'b10_01_11_00;
    for (int i = 7; i >= 0; i--) begin
      sym($sformatf("full_b%0d", i), v8[i]);
      if (i == 7) chk1("full_rdy_after_pop", code_rdy, 1'b1);
    end
    tick();
    chk1("full_idle_busy", ser_busy, 1'b0);
    sym_ce = 1'b1;
    tick();
    sym_ce = 1'b0;
    chk1("idle_sym_ce_ignored", tx_sym_vld, 1'b0);

    // ---- underrun then resume with 2'b11
    ser_en = 1'b1;
    wr2(2'b01);
    tick();
    chk1("ur_cleared_on_start", underrun, 1'b0);
    sym("ur_a0", 1'b0);
    sym("ur_a1", 1'b1);
    chk1("ur_flag", underrun, 1'b1);
    sym_ce = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1($sformatf("ur_novld%0d", k), tx_sym_vld, 1'b0);
    end
    sym_ce = 1'b0;
    wr2(2'b11);
    ser_en = 1'b0;
    sym("ur_r0", 1'b1);
    sym("ur_r1", 1'b1);
    tick();
    chk1("ur_idle_busy", ser_busy, 1'b0);
    chk1("ur_sticky", underrun, 1'b1);

    // ---- scheme latched at S=8; s dropped mid-packet must not shorten words
    ser_en = 1'b0;
    wr8(8'hA5);
    tick();
    s = 1'b0; code_data_2 = 2'b11; code_data_8 = 8'hFF; code_wr = 1'b1;
    tick();
    code_wr = 1'b0;
    v16 = 16'hA503;
    for (int i = 15; i >= 0; i--) sym($sformatf("lat_b%0d", i), v16[i]);
    tick();
    chk1("lat_idle_busy", ser_busy, 1'b0);
`ifdef CODED_SER_STATUS_EN
    chk16("lat_sym_cnt", sym_cnt, 16'd16);
`endif

    // ---- asynchronous reset mid-word
    ser_en = 1'b1;
    wr8(8'hFF);
    tick();
    wr8(8'h81);
    sym("rw_0", 1'b1);
    sym("rw_1", 1'b1);
    sym("rw_2", 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst_tx_sym", tx_sym, 1'b0);
    chk1("arst_vld", tx_sym_vld, 1'b0);
    chk1("arst_busy", ser_busy, 1'b0);
    chk1("arst_code_rdy", code_rdy, 1'b1);
    #2 rst_n = 1'b1;
    sym_ce = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1($sformatf("arst_fifo_empty%0d", k), ser_busy, 1'b0);
      chk1($sformatf("arst_novld%0d", k), tx_sym_vld, 1'b0);
    end
    sym_ce = 1'b0;
    ser_en = 1'b0;
    wr2(2'b10);
    tick();
    sym("post_0", 1'b1);
    sym("post_1", 1'b0);
    tick();
    chk1("post_idle_busy", ser_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
